// File: rtl/pwm_motor_pkg.sv
// pwm_motor_array shared definitions: register map, bit positions
// and the address-width helper.
package pwm_motor_pkg;

    localparam int REG_CTRL      = 0;
    localparam int REG_PERIOD    = 1;
    localparam int REG_STATUS    = 2;
    localparam int REG_CNT       = 3;
    localparam int REG_DUTY_BASE = 4;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_WDT_EN   = 1;
    localparam int STAT_TRIPPED  = 0;
    localparam int DUTY_DIR      = 31;

    function automatic int addr_w(input int num_ch);
        return $clog2(num_ch + REG_DUTY_BASE);
    endfunction

endpackage

// File: rtl/pwm_motor_array_if.sv
// Avalon-MM slave bundle for the motor PWM array.
// No waitrequest: writes finish in one cycle, reads return a cycle later.
interface pwm_motor_array_if
    import pwm_motor_pkg::*;
#(
    parameter int NUM_CH = 8
) ();

    localparam int ADDR_W = addr_w(NUM_CH);

    logic [ADDR_W-1:0] address;
    logic              write;
    logic [31:0]       writedata;
    logic              read;
    logic [31:0]       readdata;

    modport master (
        output address, write, writedata, read,
        input  readdata
    );

    modport slave (
        input  address, write, writedata, read,
        output readdata
    );

endinterface

// File: rtl/pwm_channel.sv
// One motor channel: shadow and active duty/direction plus the
// registered compare that drives the pin.
module pwm_channel #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] duty_i,
    input  logic             dir_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             run_i,
    input  logic             pwm_en_i,
    output logic             pwm_o,
    output logic             dir_o,
    output logic [CNT_W-1:0] duty_sh_o,
    output logic             dir_sh_o
);

    logic [CNT_W-1:0] duty_sh_q;
    logic [CNT_W-1:0] duty_act_q;
    logic             dir_sh_q;
    logic             dir_act_q;
    logic             pwm_q;
    logic             dir_q;

    // A write landing on the terminal cycle still hands the old
    // shadow to the active copy; the new value waits a full period.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            duty_sh_q  <= '0;
            duty_act_q <= '0;
            dir_sh_q   <= 1'b0;
            dir_act_q  <= 1'b0;
            pwm_q      <= 1'b0;
            dir_q      <= 1'b0;
        end else begin
            if (wr_i) begin
                duty_sh_q <= duty_i;
                dir_sh_q  <= dir_i;
            end
            if (load_i) begin
                duty_act_q <= duty_sh_q;
                dir_act_q  <= dir_sh_q;
            end
            pwm_q <= pwm_en_i && (cnt_i < duty_act_q);
            dir_q <= run_i && dir_act_q;
        end
    end

    assign pwm_o     = pwm_q;
    assign dir_o     = dir_q;
    assign duty_sh_o = duty_sh_q;
    assign dir_sh_o  = dir_sh_q;

endmodule

// File: rtl/pwm_motor_array.sv
// N-channel thruster PWM/direction generator on an Avalon-MM slave,
// with shadowed period/duty and a write-refreshed watchdog.
module pwm_motor_array
    import pwm_motor_pkg::*;
#(
    parameter int NUM_CH         = 8,
    parameter int CNT_W          = 16,
    parameter int DEFAULT_PERIOD = 2500,
    parameter int WDT_CYCLES     = 5000000
) (
    input  logic              clk_50,
    input  logic              reset,
    pwm_motor_array_if.slave  avs,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [NUM_CH-1:0] dir_out,
    output logic              wdt_tripped
);

    localparam int ADDR_W = addr_w(NUM_CH);
    localparam int WDT_W  = $clog2(WDT_CYCLES + 1);

    localparam logic [CNT_W-1:0] PER_RST  = CNT_W'(DEFAULT_PERIOD);
    localparam logic [WDT_W-1:0] WDT_LOAD = WDT_W'(WDT_CYCLES);

    logic              en_q;
    logic              wdt_en_q;
    logic              tripped_q, tripped_d;
    logic [CNT_W-1:0]  per_sh_q;
    logic [CNT_W-1:0]  per_act_q, per_act_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WDT_W-1:0]  wdt_q, wdt_d;
    logic [31:0]       rdata_q;
    logic [31:0]       rd_val;

    logic              wr_ctrl;
    logic              wr_period;
    logic              wr_clear;
    logic [NUM_CH-1:0] wr_duty;
    logic              terminal;
    logic              run;
    logic              pwm_en;

    logic [CNT_W-1:0]  duty_sh [NUM_CH];
    logic [NUM_CH-1:0] dir_sh;

    wire unused_wdata = ^avs.writedata;

    assign wr_ctrl   = avs.write && (avs.address == ADDR_W'(REG_CTRL));
    assign wr_period = avs.write && (avs.address == ADDR_W'(REG_PERIOD));
    assign wr_clear  = avs.write && (avs.address == ADDR_W'(REG_STATUS))
                       && avs.writedata[STAT_TRIPPED];

    assign terminal = (per_act_q != '0) && (cnt_q == per_act_q - CNT_W'(1));
    assign run      = en_q && !tripped_q;
    // A zero period parks every output low.
    assign pwm_en   = run && (per_act_q != '0);

    always_comb begin
        cnt_d     = cnt_q;
        per_act_d = per_act_q;
        if (terminal) begin
            cnt_d     = '0;
            per_act_d = per_sh_q;
        end else if (per_act_q != '0) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        wdt_d     = wdt_q;
        tripped_d = tripped_q;
        if (wr_clear) begin
            wdt_d     = WDT_LOAD;
            tripped_d = 1'b0;
        end else if ((|wr_duty) || !wdt_en_q) begin
            wdt_d = WDT_LOAD;
        end else if (wdt_q <= WDT_W'(1)) begin
            wdt_d     = '0;
            tripped_d = 1'b1;
        end else begin
            wdt_d = wdt_q - WDT_W'(1);
        end
    end

    always_comb begin
        rd_val = '0;
        if (avs.address == ADDR_W'(REG_CTRL)) begin
            rd_val[CTRL_EN]     = en_q;
            rd_val[CTRL_WDT_EN] = wdt_en_q;
        end else if (avs.address == ADDR_W'(REG_PERIOD)) begin
            rd_val[CNT_W-1:0] = per_sh_q;
        end else if (avs.address == ADDR_W'(REG_STATUS)) begin
            rd_val[STAT_TRIPPED] = tripped_q;
        end else if (avs.address == ADDR_W'(REG_CNT)) begin
            rd_val[CNT_W-1:0] = cnt_q;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (avs.address == ADDR_W'(REG_DUTY_BASE + i)) begin
                rd_val[CNT_W-1:0] = duty_sh[i];
                rd_val[DUTY_DIR]  = dir_sh[i];
            end
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            en_q      <= 1'b0;
            wdt_en_q  <= 1'b0;
            tripped_q <= 1'b0;
            per_sh_q  <= PER_RST;
            per_act_q <= PER_RST;
            cnt_q     <= '0;
            wdt_q     <= WDT_LOAD;
            rdata_q   <= '0;
        end else begin
            if (wr_ctrl) begin
                en_q     <= avs.writedata[CTRL_EN];
                wdt_en_q <= avs.writedata[CTRL_WDT_EN];
            end
            if (wr_period) begin
                per_sh_q <= avs.writedata[CNT_W-1:0];
            end
            if (avs.read) begin
                rdata_q <= rd_val;
            end
            tripped_q <= tripped_d;
            per_act_q <= per_act_d;
            cnt_q     <= cnt_d;
            wdt_q     <= wdt_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_duty[i] = avs.write
                            && (avs.address == ADDR_W'(REG_DUTY_BASE + i));

        pwm_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_i     (clk_50),
            .reset_i   (reset),
            .wr_i      (wr_duty[i]),
            .duty_i    (avs.writedata[CNT_W-1:0]),
            .dir_i     (avs.writedata[DUTY_DIR]),
            .load_i    (terminal),
            .cnt_i     (cnt_q),
            .run_i     (run),
            .pwm_en_i  (pwm_en),
            .pwm_o     (pwm_out[i]),
            .dir_o     (dir_out[i]),
            .duty_sh_o (duty_sh[i]),
            .dir_sh_o  (dir_sh[i])
        );
    end

    assign avs.readdata = rdata_q;
    assign wdt_tripped  = tripped_q;

endmodule

// File: tb/tb_pwm_motor_array.sv
// Bench for pwm_motor_array: directed scenarios plus random bus traffic
// against a behavioural model of the register map and waveforms.
module tb_pwm_motor_array;
    import pwm_motor_pkg::*;

    localparam int NUM_CH  = 5;
    localparam int CNT_W   = 16;
    localparam int DEF_PER = 20;
    localparam int WDT     = 100;
    localparam int ADDR_W  = addr_w(NUM_CH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NUM_CH-1:0] pwm;
    logic [NUM_CH-1:0] dir;
    logic trip;

    always #5 clk = ~clk;

    pwm_motor_array_if #(.NUM_CH(NUM_CH)) bif ();

    pwm_motor_array #(
        .NUM_CH         (NUM_CH),
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (DEF_PER),
        .WDT_CYCLES     (WDT)
    ) dut (
        .clk_50      (clk),
        .reset       (rst),
        .avs         (bif),
        .pwm_out     (pwm),
        .dir_out     (dir),
        .wdt_tripped (trip)
    );

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // Behavioural model: the watchdog is tracked as idle time since the
    // last refresh rather than as a down-counter.
    bit m_en, m_wen, m_trip;
    int m_per_sh, m_per, m_cnt, m_idle;
    int m_dsh [NUM_CH];
    int m_dact[NUM_CH];
    bit m_rsh [NUM_CH];
    bit m_ract[NUM_CH];
    logic [NUM_CH-1:0] m_pwm, m_dir;
    logic [31:0] m_rd;

    function automatic logic [31:0] m_reg(input int a);
        logic [31:0] v;
        v = '0;
        if (a == 0) v = {30'd0, m_wen, m_en};
        else if (a == 1) v = 32'(m_per_sh);
        else if (a == 2) v = 32'(m_trip);
        else if (a == 3) v = 32'(m_cnt);
        else if (a >= 4 && a < 4 + NUM_CH) begin
            v = 32'(m_dsh[a-4]);
            v[31] = m_rsh[a-4];
        end
        return v;
    endfunction

    always @(posedge clk) begin : model
        int a;
        logic [31:0] d;
        bit refresh;
        a = int'(bif.address);
        d = bif.writedata;
        if (rst) begin
            m_en = 0; m_wen = 0; m_trip = 0;
            m_per_sh = DEF_PER; m_per = DEF_PER; m_cnt = 0; m_idle = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_dsh[i] = 0; m_dact[i] = 0; m_rsh[i] = 0; m_ract[i] = 0;
            end
            m_pwm = '0; m_dir = '0; m_rd = '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_pwm[i] = m_en && !m_trip && m_per != 0 && m_cnt < m_dact[i];
                m_dir[i] = m_en && !m_trip && m_ract[i];
            end
            if (bif.read) m_rd = m_reg(a);
            if (m_per != 0) begin
                if (m_cnt == m_per - 1) begin
                    m_cnt = 0;
                    m_per = m_per_sh;
                    for (int i = 0; i < NUM_CH; i++) begin
                        m_dact[i] = m_dsh[i];
                        m_ract[i] = m_rsh[i];
                    end
                end else begin
                    m_cnt++;
                end
            end
            refresh = bif.write && a >= 4 && a < 4 + NUM_CH;
            if (bif.write && a == 2 && d[0]) begin
                m_idle = 0;
                m_trip = 0;
            end else if (refresh || !m_wen) begin
                m_idle = 0;
            end else begin
                if (m_idle < WDT) m_idle++;
                if (m_idle == WDT) m_trip = 1;
            end
            if (bif.write) begin
                if (a == 0) begin
                    m_en = d[0];
                    m_wen = d[1];
                end else if (a == 1) begin
                    m_per_sh = int'(d[15:0]);
                end else if (refresh) begin
                    m_dsh[a-4] = int'(d[15:0]);
                    m_rsh[a-4] = d[31];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check_eq("pwm_out", 32'(pwm), 32'(m_pwm));
            check_eq("dir_out", 32'(dir), 32'(m_dir));
            check_eq("wdt_tripped", 32'(trip), 32'(m_trip));
            check_eq("readdata", bif.readdata, m_rd);
        end
    end

    task automatic bus(input bit w, input bit r, input int a,
                       input logic [31:0] d);
        bif.write = w;
        bif.read = r;
        bif.address = ADDR_W'(a);
        bif.writedata = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) bus(0, 0, 0, 0);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus(1, 0, a, d);
    endtask

    task automatic rd(input int a);
        bus(0, 1, a, 0);
    endtask

    task automatic count_high(input int ch, input int n, output int hi);
        hi = 0;
        repeat (n) begin
            bus(0, 0, 0, 0);
            hi += int'(pwm[ch]);
        end
    endtask

    task automatic sync_cnt(input int target, input string tag);
        bit ok;
        ok = 0;
        for (int k = 0; k < 64; k++) begin
            if (m_cnt == target) begin
                ok = 1;
                break;
            end
            idle(1);
        end
        check_eq(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int hi;
        int a;
        logic [31:0] d;
        bif.write = 0; bif.read = 0; bif.address = '0; bif.writedata = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_on = 1'b1;
        check_eq("rst_pwm", 32'(pwm), 32'd0);
        check_eq("rst_trip", 32'(trip), 32'd0);
        check_eq("rst_rdata", bif.readdata, 32'd0);
        rd(1);
        check_eq("rst_period", bif.readdata, 32'(DEF_PER));

        wr(0, 32'h1);
        wr(1, 32'd10);
        wr(4, 32'd3);
        idle(45);
        count_high(0, 10, hi);
        check_eq("duty3_highs", 32'(hi), 32'd3);
        check_eq("duty3_dir", 32'(dir[0]), 32'd0);

        sync_cnt(4, "sync_cnt4");
        wr(4, 32'h8000_0007);
        count_high(0, 5, hi);
        check_eq("old_period_tail", 32'(hi), 32'd0);
        check_eq("dir_before_cnt0", 32'(dir[0]), 32'd0);
        idle(1);
        check_eq("pwm_at_cnt0", 32'(pwm[0]), 32'd1);
        check_eq("dir_at_cnt0", 32'(dir[0]), 32'd1);
        count_high(0, 9, hi);
        check_eq("duty7_rest", 32'(hi), 32'd6);

        wr(5, 32'd10);
        wr(6, 32'd0);
        idle(30);
        count_high(1, 10, hi);
        check_eq("duty_ge_period", 32'(hi), 32'd10);
        count_high(2, 10, hi);
        check_eq("duty_zero", 32'(hi), 32'd0);

        wr(0, 32'h3);
        wr(7, 32'd5);
        idle(99);
        check_eq("wdt_not_yet", 32'(trip), 32'd0);
        idle(1);
        check_eq("wdt_trip", 32'(trip), 32'd1);
        idle(1);
        check_eq("wdt_pwm_off", 32'(pwm), 32'd0);
        check_eq("wdt_dir_off", 32'(dir), 32'd0);
        rd(2);
        check_eq("status_tripped", bif.readdata, 32'd1);
        wr(2, 32'h1);
        check_eq("wdt_cleared", 32'(trip), 32'd0);
        wr(0, 32'h1);
        idle(10);
        count_high(0, 10, hi);
        check_eq("resume_highs", 32'(hi), 32'd7);

        sync_cnt(6, "sync_cnt6");
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_eq("midrst_pwm", 32'(pwm), 32'd0);
        check_eq("midrst_dir", 32'(dir), 32'd0);
        rd(3);
        check_eq("midrst_cnt", bif.readdata, 32'd0);
        rd(1);
        check_eq("midrst_period", bif.readdata, 32'(DEF_PER));
        rd(4);
        check_eq("midrst_duty0", bif.readdata, 32'd0);

        wr(0, 32'h1);
        wr(4, 32'd8);
        wr(5, 32'h8000_0003);
        wr(1, 32'hABCD_0000);
        idle(50);
        check_eq("per0_pwm", 32'(pwm), 32'd0);
        rd(3);
        check_eq("per0_cnt", bif.readdata, 32'd0);
        rd(5);
        check_eq("duty1_readback", bif.readdata, 32'h8000_0003);
        rd(NUM_CH + 4);
        check_eq("unmapped", bif.readdata, 32'd0);

        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 63) == 0) begin
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
            end
            a = int'($urandom_range(0, (1 << ADDR_W) - 1));
            d = $urandom;
            if (a == 1) d[15:0] = 16'($urandom_range(0, 15));
            else if (a >= 4) d[15:0] = 16'($urandom_range(0, 17));
            bus(1'($urandom), 1'($urandom), a, d);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
